// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared writeback types, source ids and default sizes
package wb_arbiter_pkg;
  localparam int REG_WIDTH = 5;
  localparam int WB_NUM_SRC = 4;
  localparam int WB_FIFO_DEPTH = 4;
  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MUL,
    WB_SRC_DIV,
    WB_SRC_LSU
  } wb_src_e;
  typedef struct packed {
    logic                 instruction_valid;
    logic                 register_write;
    logic [REG_WIDTH-1:0] rd;
    logic [31:0]          exe_result;
  } exe_wb_inf_t;
  typedef struct packed {
    logic [REG_WIDTH-1:0] rd;
    logic [31:0]          data;
  } wb_entry_t;
  function automatic logic [31:0] rd_bit(logic [REG_WIDTH-1:0] rd);
    return (32'd1 << rd) & ~32'd1;
  endfunction
endpackage

// File: rtl/wb_src_fifo.sv
// wb_src_fifo: per-source result FIFO; rd_mask of live entries when WB_PENDING_MASK_EN is defined
module wb_src_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int AFULL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  wb_entry_t                wentry,
  output wb_entry_t                rentry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     afull
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [31:0]              rd_mask
`endif
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic wr;
  assign full = count == (AW+1)'(DEPTH);
  assign afull = count >= (AW+1)'(AFULL);
  // a push into a full FIFO still lands when the same cycle pops
  assign wr = push & (~full | pop);
  assign rentry = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= wentry;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
`ifdef WB_PENDING_MASK_EN
  always_comb begin
    rd_mask = '0;
    for (int k = 0; k < DEPTH; k++)
      if ({1'b0, AW'(AW'(k) - rptr)} < count) rd_mask = rd_mask | rd_bit(mem[k].rd);
  end
`endif
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: buffers execution-unit results per source and round-robins one register-file write per cycle.
// Optional WB_PENDING_MASK_EN adds pending_mask[31:0] for dispatcher hazard checks.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = WB_NUM_SRC,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
  parameter int AFULL_LEVEL = FIFO_DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  exe_wb_inf_t [NUM_SRC-1:0]     exe_wb_inf,
  output logic [NUM_SRC-1:0]            src_afull,
  output logic                          rf_we,
  output logic [REG_WIDTH-1:0]          rf_waddr,
  output logic [31:0]                   rf_wdata,
  output logic                          overflow_err
`ifdef WB_PENDING_MASK_EN
  ,
  output logic [31:0]                   pending_mask
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  logic [NUM_SRC-1:0] push, pop, full, empty, drop;
  logic [CW-1:0] count [NUM_SRC];
  wb_entry_t rentry [NUM_SRC];
  logic [SW-1:0] rr_ptr, gnt, nxt;
  logic any;
`ifdef WB_PENDING_MASK_EN
  logic [31:0] src_mask [NUM_SRC];
`endif
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign push[i] = exe_wb_inf[i].instruction_valid & exe_wb_inf[i].register_write & (exe_wb_inf[i].rd != '0);
    assign empty[i] = count[i] == '0;
    assign pop[i] = any & (gnt == SW'(i));
    assign drop[i] = push[i] & full[i] & ~pop[i];
    wb_src_fifo #(.DEPTH(FIFO_DEPTH), .AFULL(AFULL_LEVEL)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push[i]),
      .pop    (pop[i]),
      .wentry ({exe_wb_inf[i].rd, exe_wb_inf[i].exe_result}),
      .rentry (rentry[i]),
      .count  (count[i]),
      .full   (full[i]),
      .afull  (src_afull[i])
`ifdef WB_PENDING_MASK_EN
      ,
      .rd_mask(src_mask[i])
`endif
    );
  end
  // scan from the far end so the source closest to rr_ptr wins
  always_comb begin
    any = 1'b0;
    gnt = rr_ptr;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (!empty[(int'(rr_ptr) + k) % NUM_SRC]) begin
        any = 1'b1;
        gnt = SW'((int'(rr_ptr) + k) % NUM_SRC);
      end
    nxt = int'(gnt) == NUM_SRC - 1 ? '0 : gnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      overflow_err <= 1'b0;
      rr_ptr <= '0;
    end else begin
      rf_we <= any;
      if (any) begin
        rf_waddr <= rentry[gnt].rd;
        rf_wdata <= rentry[gnt].data;
        rr_ptr <= nxt;
      end
      if (|drop) overflow_err <= 1'b1;
    end
  end
`ifdef WB_PENDING_MASK_EN
  always_comb begin
    pending_mask = rf_we ? rd_bit(rf_waddr) : '0;
    for (int k = 0; k < NUM_SRC; k++) pending_mask = pending_mask | src_mask[k];
  end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a queue-based model
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  localparam int NS = 4;
  localparam int DEPTH = 4;
  localparam int AFL = 2;
  logic clk, rst;
  exe_wb_inf_t [NS-1:0] in;
  logic [NS-1:0] src_afull;
  logic rf_we, overflow_err;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
`ifdef WB_PENDING_MASK_EN
  logic [31:0] pending_mask;
`endif
  int checks = 0;
  int errors = 0;
  wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .exe_wb_inf  (in),
    .src_afull   (src_afull),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .overflow_err(overflow_err)
`ifdef WB_PENDING_MASK_EN
    ,
    .pending_mask(pending_mask)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  // reference model: one queue per source, plain round-robin search
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;
  ent_t q [NS][$];
  int rr = 0;
  bit mvalid = 0;
  bit e_we = 0;
  bit e_ov = 0;
  logic [4:0] e_wa = '0;
  logic [31:0] e_wd = '0;
  always @(posedge clk) begin : model
    int g;
    ent_t e;
    if (rst) begin
      for (int i = 0; i < NS; i++) q[i].delete();
      rr = 0;
      e_we = 0;
      e_wa = '0;
      e_wd = '0;
      e_ov = 0;
      mvalid = 1;
    end else begin
      g = -1;
      for (int k = 0; k < NS; k++)
        if (g < 0 && q[(rr + k) % NS].size() > 0) g = (rr + k) % NS;
      e_we = g >= 0;
      if (g >= 0) begin
        e = q[g].pop_front();
        e_wa = e.rd;
        e_wd = e.d;
        rr = (g + 1) % NS;
      end
      for (int i = 0; i < NS; i++)
        if (in[i].instruction_valid && in[i].register_write && in[i].rd != 0) begin
          if (q[i].size() < DEPTH) q[i].push_back({in[i].rd, in[i].exe_result});
          else e_ov = 1;
        end
    end
  end
  function automatic logic [NS-1:0] model_afull();
    logic [NS-1:0] a;
    for (int i = 0; i < NS; i++) a[i] = q[i].size() >= AFL;
    return a;
  endfunction
`ifdef WB_PENDING_MASK_EN
  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    if (e_we) m[e_wa] = 1'b1;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < q[i].size(); j++) m[q[i][j].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction
`endif
  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_rf_we", rf_we, e_we);
      chk("model_rf_waddr", rf_waddr, e_wa);
      chk("model_rf_wdata", rf_wdata, e_wd);
      chk("model_src_afull", src_afull, model_afull());
      chk("model_overflow", overflow_err, e_ov);
`ifdef WB_PENDING_MASK_EN
      chk("model_pending", pending_mask, model_mask());
`endif
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic pulse(int s, bit iv, bit rw, logic [4:0] rd, logic [31:0] d);
    in[s].instruction_valid = iv;
    in[s].register_write = rw;
    in[s].rd = rd;
    in[s].exe_result = d;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic burst(int first, string name);
    logic [4:0] exp_rd;
    for (int s = 0; s < NS; s++) pulse(s, 1, 1, 5'(s + 1), 32'h100 + 32'(s));
    tick();
    in = '0;
    chk({name, "_lat"}, rf_we, 0);
    for (int k = 0; k < NS; k++) begin
      tick();
      exp_rd = 5'((first + k) % NS + 1);
      chk({name, "_we"}, rf_we, 1);
      chk({name, "_rd"}, rf_waddr, exp_rd);
    end
    tick();
    chk({name, "_idle"}, rf_we, 0);
  endtask
  initial begin
    rst = 1'b1;
    in = '0;
    tick();
    tick();
    chk("rst_we", rf_we, 0);
    chk("rst_afull", src_afull, 0);
    chk("rst_ovf", overflow_err, 0);
    chk("rst_waddr", rf_waddr, 0);
    rst = 1'b0;
    burst(0, "burst_rr0");
    pulse(1, 1, 1, 5'd9, 32'h99);
    tick();
    in = '0;
    tick();
    chk("mul_rd9", rf_waddr, 9);
    tick();
    burst(2, "burst_rr2");
    pulse(2, 1, 1, 5'd5, 32'hFFFF_FFF9);
    tick();
    in = '0;
    chk("div_n1", rf_we, 0);
    tick();
    chk("div_we", rf_we, 1);
    chk("div_rd", rf_waddr, 5);
    chk("div_data", rf_wdata, 32'hFFFF_FFF9);
    tick();
    chk("div_after", rf_we, 0);
    for (int c = 0; c < 10; c++) begin
      for (int s = 0; s < NS; s++)
        case ((c + s) % 3)
          0: pulse(s, 1, 1, 5'd0, $urandom);
          1: pulse(s, 1, 0, 5'(s + 3), $urandom);
          default: pulse(s, 0, 1, 5'(s + 7), $urandom);
        endcase
      tick();
      chk("ign_we", rf_we, 0);
      chk("ign_afull", src_afull, 0);
    end
    in = '0;
    tick();
    chk("ign_tail", rf_we, 0);
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      in = '0;
      pulse(0, 1, 1, 5'(10 + c), 32'(c));
      if (c <= 7) pulse(1, 1, 1, 5'(20 + c), 32'(100 + c));
      tick();
      if (c == 2) chk("flood_afull_c1", src_afull[0], 0);
      if (c == 3) chk("flood_afull_c2", src_afull[0], 1);
      if (c == 8) chk("full_push_pop", overflow_err, 0);
      if (c == 9) chk("full_push_drop", overflow_err, 1);
    end
    in = '0;
    repeat (20) tick();
    chk("ovf_sticky", overflow_err, 1);
    for (int c = 0; c < 3; c++) begin
      pulse(0, 1, 1, 5'd3, 32'(c));
      pulse(1, 1, 1, 5'd4, 32'(c));
      tick();
    end
    do_reset();
    chk("mid_rst_we", rf_we, 0);
    chk("mid_rst_afull", src_afull, 0);
    chk("mid_rst_ovf", overflow_err, 0);
    in = '0;
    repeat (6) begin
      tick();
      chk("no_stale", rf_we, 0);
    end
`ifdef WB_PENDING_MASK_EN
    pulse(3, 1, 1, 5'd7, 32'h77);
    tick();
    in = '0;
    chk("pend_n1", pending_mask[7], 1);
    tick();
    chk("pend_we", pending_mask[7], 1);
    tick();
    chk("pend_clr", pending_mask[7], 0);
`endif
    for (int c = 0; c < 800; c++) begin
      for (int s = 0; s < NS; s++) begin
        pulse(s, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
        if (src_afull[s]) in[s].instruction_valid = 1'b0;
      end
      tick();
    end
    in = '0;
    repeat (20) tick();
    chk("drain_we", rf_we, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
